// File: rtl/imem_loader.sv
// imem_loader: streams len words into instruction memory from address 0 and holds the core in reset until loaded
// Ports: clk, reset (async, active-high); start/len begin a load; in_data/in_valid/in_ready stream in;
//   mem_we/mem_addr/mem_wdata drive the imem write port (registered); core_hold, busy, done, err report status.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the data.
module imem_loader #(
  parameter int IW = 9,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [IW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [IW-1:0] mem_wdata,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t state;
  logic [AW:0] count, len_q, nxt;
  logic accept, hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [IW-1:0] csum;
  assign in_ready = state == LOAD || state == CHECK;
`else
  assign in_ready = state == LOAD;
`endif
  assign accept = start && (state == IDLE || state == DONE);
  assign hs = in_valid && in_ready;
  assign nxt = count + {{AW{1'b0}}, 1'b1};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      count <= '0;
      len_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        done <= 1'b0;
        err <= 1'b0;
        core_hold <= 1'b1;
        count <= '0;
        mem_addr <= '0;
        len_q <= len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
        if (len > DEPTH) begin
          err <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end else if (len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          busy <= 1'b1;
          state <= CHECK;
`else
          done <= 1'b1;
          core_hold <= 1'b0;
          state <= DONE;
`endif
        end else begin
          busy <= 1'b1;
          state <= LOAD;
        end
      end else if (hs && state == LOAD) begin
        mem_we <= 1'b1;
        mem_addr <= count[AW-1:0];
        mem_wdata <= in_data;
        count <= nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
        if (nxt == len_q) state <= CHECK;
`else
        // Final write and release land on the same edge, so the core never runs a half-loaded image.
        if (nxt == len_q) begin
          done <= 1'b1;
          core_hold <= 1'b0;
          busy <= 1'b0;
          state <= DONE;
        end
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // The checksum word is consumed but never written.
      else if (hs && state == CHECK) begin
        busy <= 1'b0;
        if (in_data == csum) begin
          done <= 1'b1;
          core_hold <= 1'b0;
          state <= DONE;
        end else begin
          err <= 1'b1;
          state <= IDLE;
        end
      end
`endif
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a word-list reference model
module tb_imem_loader;
  localparam int IW = 9, AW = 8, DEPTH = 256;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [AW:0] len = '0;
  logic [IW-1:0] in_data = '0;
  logic in_ready, mem_we, core_hold, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] none[$];
  int compared = 0, mismatched = 0;

  imem_loader #(.IW(IW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One complete load: the model is simply "word i lands at address i, one cycle after its handshake".
  task automatic do_load(input string nm, input int n, input logic [IW-1:0] fw[$], input int vpct,
                         input int pmask, input int plen, input bit bad);
    logic [IW-1:0] w[$];
    logic [IW-1:0] x;
    int k, cyc;
    bit pend, exp_ok;
    x = '0; k = 0; cyc = 0; pend = 0;
    for (int i = 0; i < n; i++) begin
      w.push_back(i < fw.size() ? fw[i] : IW'($urandom));
      x ^= w[i];
    end
    @(negedge clk); start = 1; len = n[AW:0];
    @(negedge clk); start = 0;
    if (n > DEPTH) begin
      for (int c = 0; c < 4; c++) begin
        compared++;
        if ({err, core_hold, done, busy, mem_we, in_ready} !== 6'b110000) begin
          mismatched++;
          $display("FAIL %s overflow c%0d: err/hold/done/busy/we/rdy=%b want 110000", nm, c,
                   {err, core_hold, done, busy, mem_we, in_ready});
        end
        @(negedge clk);
      end
      return;
    end
    while (k < n && cyc < 4000) begin
      compared++;
      if ({mem_we, in_ready, busy, done, core_hold} !== {pend, 4'b1101} ||
          (pend && {mem_addr, mem_wdata} !== {AW'(k-1), w[k-1]})) begin
        mismatched++;
        $display("FAIL %s cyc%0d: we/rdy/busy/done/hold=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                 nm, cyc, {mem_we, in_ready, busy, done, core_hold}, mem_addr, mem_wdata, pend,
                 k - 1, pend ? w[k-1] : '0);
      end
      in_valid = plen > 0 ? pmask[cyc % plen] : ($urandom_range(99) < vpct);
      in_data = w[k];
      pend = in_valid;
      if (pend) k++;
      @(negedge clk); cyc++;
    end
    in_valid = 0; in_data = '0;
    compared++;
    if (k < n) begin
      mismatched++;
      $display("FAIL %s timeout: %0d words sent, want %0d", nm, k, n);
    end
    compared++;
    if (mem_we !== (n > 0) || (n > 0 && {mem_addr, mem_wdata} !== {AW'(n-1), w[n-1]})) begin
      mismatched++;
      $display("FAIL %s last write: we=%b addr=%0d data=%h want we=%b addr=%0d", nm, mem_we, mem_addr,
               mem_wdata, n > 0, n - 1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    compared++;
    if ({in_ready, busy, done, core_hold, err} !== 5'b11010) begin
      mismatched++;
      $display("FAIL %s check state: rdy/busy/done/hold/err=%b want 11010", nm,
               {in_ready, busy, done, core_hold, err});
    end
    in_valid = 1; in_data = bad ? x ^ IW'(1) : x;
    @(negedge clk); in_valid = 0;
    exp_ok = !bad;
    compared++;
    if ({mem_we, done, err, core_hold, busy, in_ready} !== {1'b0, exp_ok, !exp_ok, !exp_ok, 2'b00}) begin
      mismatched++;
      $display("FAIL %s checksum: we/done/err/hold/busy/rdy=%b want 0%b%b%b00", nm,
               {mem_we, done, err, core_hold, busy, in_ready}, exp_ok, !exp_ok, !exp_ok);
    end
`else
    exp_ok = 1;
    compared++;
    if ({done, core_hold, busy, in_ready, err} !== 5'b10000) begin
      mismatched++;
      $display("FAIL %s completion: done/hold/busy/rdy/err=%b want 10000", nm,
               {done, core_hold, busy, in_ready, err});
    end
`endif
    @(negedge clk);
    compared++;
    if ({mem_we, in_ready, done, err, core_hold} !== {2'b00, exp_ok, !exp_ok, !exp_ok}) begin
      mismatched++;
      $display("FAIL %s settle: we/rdy/done/err/hold=%b want 00%b%b%b", nm,
               {mem_we, in_ready, done, err, core_hold}, exp_ok, !exp_ok, !exp_ok);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    reset = 0;
    for (int c = 0; c < 20; c++) begin
      compared++;
      if ({core_hold, done, err, mem_we, busy, in_ready, mem_addr, mem_wdata} !== {6'b100000, 17'd0}) begin
        mismatched++;
        $display("FAIL reset c%0d: hold/done/err/we/busy/rdy=%b addr=%0d data=%h want 100000 0 0", c,
                 {core_hold, done, err, mem_we, busy, in_ready}, mem_addr, mem_wdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    logic [IW-1:0] fw[$];
    fw = {9'h1A5, 9'h003, 9'h0FF};
    do_load("basic", 3, fw, 100, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    do_load("stall", 4, none, 0, 32'h59, 7, 0);
  endtask

  task automatic test_boundaries();
    do_load("len0", 0, none, 100, 0, 0, 0);
    do_load("len257", 257, none, 100, 0, 0, 0);
    do_load("len256", 256, none, 100, 0, 0, 0);
  endtask

  task automatic test_reset_midload();
    @(negedge clk); start = 1; len = 5;
    @(negedge clk); start = 0; in_valid = 1; in_data = 9'h011;
    @(negedge clk); in_data = 9'h022;
    @(negedge clk); start = 1; len = 2; in_data = 9'h033;
    @(negedge clk); start = 0; in_valid = 0;
    compared++;
    if ({busy, in_ready, done, mem_we, mem_addr, mem_wdata} !== {4'b1101, 8'd2, 9'h033}) begin
      mismatched++;
      $display("FAIL start-while-busy: busy/rdy/done/we=%b addr=%0d data=%h want 1101 2 033",
               {busy, in_ready, done, mem_we}, mem_addr, mem_wdata);
    end
    reset = 1; #1;
    compared++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err} !== {2'b00, 17'd0, 4'b1000}) begin
      mismatched++;
      $display("FAIL async reset: rdy/we=%b addr=%0d data=%h hold/busy/done/err=%b want 00 0 0 1000",
               {in_ready, mem_we}, mem_addr, mem_wdata, {core_hold, busy, done, err});
    end
    @(negedge clk); reset = 0;
    do_load("after-reset", 2, none, 100, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) do_load($sformatf("rand%0d", i), $urandom_range(16, 1), none, 70, 0, 0, 0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [IW-1:0] fw[$];
    fw = {9'h0F0, 9'h00F};
    do_load("csum-ok", 2, fw, 100, 0, 0, 0);
    do_load("csum-bad", 2, fw, 100, 0, 0, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_reset_midload();
    test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
